// File: rtl/press_repeater.sv
// Pushbutton auto-repeat: synchronises the active-low button, emits an initial
// step on press, then slow and fast repeat steps while the button stays held.
module press_repeater #(
  parameter int HOLD_TICKS = 10,
  parameter int SLOW_TICKS = 5,
  parameter int FAST_AFTER = 8,
  parameter int FAST_TICKS = 1,
  parameter int CNT_W      = 8
) (
  input  logic clk10hz,
  input  logic reset,
  input  logic pb,
  output logic step,
  output logic held,
  output logic fast
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_SLOW    = 2'd2;
  localparam logic [1:0] ST_FAST    = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_TICKS - 1);
  localparam logic [CNT_W-1:0] FAST_CNT  = CNT_W'(FAST_AFTER);
  localparam logic             FAST_FIRST = (FAST_AFTER == 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic             step_q, step_d;
  logic             held_q, held_d;
  logic             fast_q, fast_d;
  logic             down;
  logic [CNT_W-1:0] reps_inc;

  assign down     = ~s2_q;
  assign reps_inc = reps_q + CNT_W'(1);

  always_comb begin
    s1_d    = pb;
    s2_d    = s1_q;
    state_d = state_q;
    tick_d  = tick_q;
    reps_d  = reps_q;
    step_d  = 1'b0;
    held_d  = held_q;
    fast_d  = fast_q;

    // Release always wins over a repeat that falls due in the same cycle.
    if (state_q != ST_IDLE && !down) begin
      state_d = ST_IDLE;
      tick_d  = '0;
      reps_d  = '0;
      held_d  = 1'b0;
      fast_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          reps_d = '0;
          held_d = 1'b0;
          fast_d = 1'b0;
          if (down) begin
            state_d = ST_PRESSED;
            step_d  = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (tick_q == HOLD_LAST) begin
            tick_d = '0;
            reps_d = CNT_W'(1);
            step_d = 1'b1;
            held_d = 1'b1;
            if (FAST_FIRST) begin
              state_d = ST_FAST;
              fast_d  = 1'b1;
            end else begin
              state_d = ST_SLOW;
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        ST_SLOW: begin
          if (tick_q == SLOW_LAST) begin
            tick_d = '0;
            reps_d = reps_inc;
            step_d = 1'b1;
            if (reps_inc == FAST_CNT) begin
              state_d = ST_FAST;
              fast_d  = 1'b1;
            end
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        ST_FAST: begin
          if (tick_q == FAST_LAST) begin
            tick_d = '0;
            step_d = 1'b1;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
          reps_d  = '0;
          held_d  = 1'b0;
          fast_d  = 1'b0;
        end
      endcase
    end
  end

  // Synchroniser resets to "released" so a button held through reset re-presses.
  always_ff @(posedge clk10hz) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= ST_IDLE;
      tick_q  <= '0;
      reps_q  <= '0;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      reps_q  <= reps_d;
      step_q  <= step_d;
      held_q  <= held_d;
      fast_q  <= fast_d;
    end
  end

  assign step = step_q;
  assign held = held_q;
  assign fast = fast_q;

endmodule

// File: tb/tb_press_repeater.sv
// Randomised bench for press_repeater: two parameterisations driven by the same
// button, each compared every cycle against a hold-duration arithmetic model.
`timescale 1ns/1ps
module tb_press_repeater;

  logic clk10hz;
  logic reset;
  logic pb;
  logic step_a, held_a, fast_a;
  logic step_b, held_b, fast_b;

  int  check_count;
  int  error_count;
  bit  check_en;

  // Cycles the button has been seen down by the state logic (0 = released).
  int  run_len;
  logic sync1, sync2;

  press_repeater #(
    .HOLD_TICKS(10), .SLOW_TICKS(5), .FAST_AFTER(8), .FAST_TICKS(1), .CNT_W(8)
  ) dut_a (
    .clk10hz(clk10hz), .reset(reset), .pb(pb),
    .step(step_a), .held(held_a), .fast(fast_a)
  );

  press_repeater #(
    .HOLD_TICKS(10), .SLOW_TICKS(5), .FAST_AFTER(1), .FAST_TICKS(2), .CNT_W(8)
  ) dut_b (
    .clk10hz(clk10hz), .reset(reset), .pb(pb),
    .step(step_b), .held(held_b), .fast(fast_b)
  );

  initial clk10hz = 1'b0;
  always #5 clk10hz = ~clk10hz;

  // Expected {step, held, fast} for a hold that has lasted run cycles.
  function automatic logic [2:0] expectOut(int run, int hold, int slow, int fa, int ft);
    int  c, fast_start;
    logic st, h, f;
    if (run == 0) return 3'b000;
    c          = run - 1;
    fast_start = hold + (fa - 1) * slow;
    h          = (c >= hold);
    f          = (c >= fast_start);
    st         = (c == 0);
    if (h && !f) st = ((c - hold) % slow == 0);
    if (f)       st = ((c - fast_start) % ft == 0);
    return {st, h, f};
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got step/held/fast=%b, expected %b (run=%0d)",
               tag, $time, observed, expected, run_len);
    end
  endtask

  task automatic applyStimulus(input logic pb_val, input logic reset_val, input int cycles);
    pb    = pb_val;
    reset = reset_val;
    repeat (cycles) @(posedge clk10hz);
    #2;
  endtask

  // Low pulse that starts and ends between two rising edges.
  task automatic applyGlitch();
    pb = 1'b0;
    #3;
    pb = 1'b1;
    @(posedge clk10hz);
    #2;
  endtask

  always @(posedge clk10hz) begin
    if (reset) begin
      sync1   = 1'b1;
      sync2   = 1'b1;
      run_len = 0;
    end else begin
      run_len = (sync2 == 1'b0) ? run_len + 1 : 0;
      sync2   = sync1;
      sync1   = pb;
    end
  end

  always @(negedge clk10hz) begin
    if (check_en) begin
      checkOutput("dflt", {step_a, held_a, fast_a}, expectOut(run_len, 10, 5, 8, 1));
      checkOutput("fa1ft2", {step_b, held_b, fast_b}, expectOut(run_len, 10, 5, 1, 2));
    end
  end

  initial begin
    check_count = 0;
    error_count = 0;
    check_en    = 1'b0;
    run_len     = 0;
    sync1       = 1'b1;
    sync2       = 1'b1;
    pb          = 1'b0;
    reset       = 1'b1;
    @(posedge clk10hz);
    #2;
    check_en = 1'b1;

    // Reset held with button down, then released with the button still down.
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 6);

    // Short press, then a glitch nobody samples.
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 8);
    applyGlitch();
    applyStimulus(1'b1, 1'b0, 5);

    // Full hold long enough to reach the fast region.
    applyStimulus(1'b0, 1'b0, 62);
    applyStimulus(1'b1, 1'b0, 6);

    // Release so the state logic sees the button up exactly at a due repeat.
    applyStimulus(1'b0, 1'b0, 15);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 20);
    applyStimulus(1'b1, 1'b0, 5);

    // Reset pulse during FAST with the button still held.
    applyStimulus(1'b0, 1'b0, 50);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 25);
    applyStimulus(1'b1, 1'b0, 5);

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'b1, $urandom_range(1, 2));
      end else if (r == 1) begin
        applyGlitch();
      end else begin
        applyStimulus(1'b0, 1'b0, $urandom_range(1, 70));
        applyStimulus(1'b1, 1'b0, $urandom_range(1, 6));
      end
    end

    applyStimulus(1'b1, 1'b0, 5);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
